// File: rtl/mm2s_engine.sv
// mm2s_engine: memory-to-stream read engine.
// A (start address, byte length) command is split into AXI-MM read bursts.
// Read data is buffered in an internal FIFO and replayed as AXI-Stream with
// tkeep/tlast marking the final, possibly partial, word of the command.
// Optional build macro MM2S_4K_SPLIT_EN: when defined, bursts are also cut
// so that none crosses a 4 KB address boundary.
//
// Handshakes: every channel transfers on a cycle where valid && ready are
// both high at the rising clock edge. Once valid is raised, it and its
// payload stay unchanged until that transfer happens.
module mm2s_engine #(
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      m_axi_araddr,
   output logic [7:0]       m_axi_arlen,
   output logic             m_axi_arvalid,
   input  logic             m_axi_arready,
   input  logic [31:0]      m_axi_rdata,
   input  logic [1:0]       m_axi_rresp,
   input  logic             m_axi_rlast,
   input  logic             m_axi_rvalid,
   output logic             m_axi_rready,
   output logic [31:0]      m_axis_tdata,
   output logic [3:0]       m_axis_tkeep,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic [1:0]       dbg_state_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_DATA  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] beats_left_q, beats_left_d;
   logic [LEN_W-1:0] out_left_q, out_left_d;
   logic [1:0]       len_lo_q, len_lo_d;
   logic             err_sticky_q, err_sticky_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;

   logic [LEN_W:0]   cmd_beats;
   logic [LEN_W-1:0] burst;
   logic [12:0]      lim4k;
   logic [CW-1:0]    free;
   logic             space_ok, ar_hs, push, pop, last_beat;

   assign cmd_beats = ({1'b0, cmd_len} + (LEN_W+1)'(3)) >> 2;
   assign free      = CW'(FIFO_DEPTH) - count_q;

`ifdef MM2S_4K_SPLIT_EN
   // words left before the next 4 KB boundary
   assign lim4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> 2;
`else
   // caller keeps the region inside one 4 KB page; this never limits
   assign lim4k = 13'd4096;
`endif

   // burst size: smallest of remaining words, MAX_BURST and page limit
   always_comb begin
      burst = beats_left_q;
      if (burst > LEN_W'(MAX_BURST)) burst = LEN_W'(MAX_BURST);
      if (burst > LEN_W'(lim4k))     burst = LEN_W'(lim4k);
   end

   // a burst is only requested once the FIFO can absorb all of it
   assign space_ok      = LEN_W'(free) >= burst;
   assign m_axi_arvalid = (state_q == S_ADDR) && space_ok;
   assign m_axi_araddr  = (state_q == S_ADDR) ? addr_q : 32'h0;
   assign m_axi_arlen   = (state_q == S_ADDR) ? 8'(burst - LEN_W'(1)) : 8'h0;
   assign ar_hs         = m_axi_arvalid && m_axi_arready;
   assign m_axi_rready  = (state_q == S_DATA);
   assign push          = m_axi_rready && m_axi_rvalid;
   assign m_axis_tvalid = (count_q != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign last_beat     = (out_left_q == LEN_W'(1));

   assign cmd_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

   assign m_axis_tdata = m_axis_tvalid ? mem_q[rd_ptr_q] : 32'h0;
   assign m_axis_tlast = m_axis_tvalid && last_beat;

   // final word keeps only the bytes covered by the command length
   always_comb begin
      m_axis_tkeep = 4'h0;
      if (m_axis_tvalid) begin
         m_axis_tkeep = 4'hF;
         if (last_beat) begin
            case (len_lo_q)
               2'd1:    m_axis_tkeep = 4'h1;
               2'd2:    m_axis_tkeep = 4'h3;
               2'd3:    m_axis_tkeep = 4'h7;
               default: m_axis_tkeep = 4'hF;
            endcase
         end
      end
   end

   // next-state logic for the command/burst sequencer
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      out_left_d   = out_left_q;
      len_lo_d     = len_lo_q;
      err_sticky_d = err_sticky_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      if (pop) out_left_d = out_left_q - LEN_W'(1);
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d       = cmd_addr;
               beats_left_d = cmd_beats[LEN_W-1:0];
               out_left_d   = cmd_beats[LEN_W-1:0];
               len_lo_d     = cmd_len[1:0];
               err_sticky_d = 1'b0;
               state_d      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (ar_hs) begin
               addr_d       = addr_q + (32'(burst) << 2);
               beats_left_d = beats_left_q - burst;
               state_d      = S_DATA;
            end
         end
         S_DATA: begin
            if (push && (m_axi_rresp != 2'b00)) err_sticky_d = 1'b1;
            if (push && m_axi_rlast)
               state_d = (beats_left_q == '0) ? S_FLUSH : S_ADDR;
         end
         S_FLUSH: begin
            if (pop && last_beat) begin
               done_d  = 1'b1;
               err_d   = err_sticky_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // sequencer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= 32'h0;
         beats_left_q <= '0;
         out_left_q   <= '0;
         len_lo_q     <= 2'd0;
         err_sticky_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         out_left_q   <= out_left_d;
         len_lo_q     <= len_lo_d;
         err_sticky_q <= err_sticky_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // FIFO pointers and occupancy; push+pop together leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage, written on every R handshake
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= m_axi_rdata;
   end

endmodule

// File: tb/tb_mm2s_engine.sv
// tb_mm2s_engine: self-checking bench for mm2s_engine with an AXI read
// slave model, randomised ready/valid throttling and a stream scoreboard.
module tb_mm2s_engine;

   localparam int MAX_BURST  = 16;
   localparam int FIFO_DEPTH = 32;
   localparam int LEN_W      = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_valid;
   logic             cmd_ready, busy, done, err;
   logic [31:0]      m_axi_araddr;
   logic [7:0]       m_axi_arlen;
   logic             m_axi_arvalid, m_axi_arready;
   logic [31:0]      m_axi_rdata;
   logic [1:0]       m_axi_rresp;
   logic             m_axi_rlast, m_axi_rvalid, m_axi_rready;
   logic [31:0]      m_axis_tdata;
   logic [3:0]       m_axis_tkeep;
   logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [1:0]       dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [36:0] exp_q[$];
   logic [36:0] got_q[$];
   logic [39:0] exp_ar_q[$];
   logic [39:0] got_ar_q[$];
   int done_cnt      = 0;
   int err_cnt       = 0;
   int err_alone_cnt = 0;

   bit          tready_rand = 1'b0;
   bit          tready_fix  = 1'b1;
   logic [31:0] err_addr    = 32'hFFFF_FFFF;

   mm2s_engine #(
      .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .busy(busy), .done(done), .err(err),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .dbg_state_o(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] beat_data(input logic [31:0] a);
      return (a * 32'h0101_0107) + 32'h1357_9BDF;
   endfunction

   function automatic logic [3:0] final_keep(input int len);
      case (len % 4)
         1:       return 4'h1;
         2:       return 4'h3;
         3:       return 4'h7;
         default: return 4'hF;
      endcase
   endfunction

   // expected stream beats and AR bursts for one command
   task automatic expect_cmd(input logic [31:0] addr, input int len);
      int beats, rem, b, lim;
      logic [31:0] a;
      beats = (len + 3) / 4;
      for (int i = 0; i < beats; i++)
         exp_q.push_back({(i == beats - 1), (i == beats - 1) ? final_keep(len) : 4'hF,
                          beat_data(addr + 32'(4 * i))});
      rem = beats;
      a = addr;
      while (rem > 0) begin
         b = (rem < MAX_BURST) ? rem : MAX_BURST;
         lim = 1024;
`ifdef MM2S_4K_SPLIT_EN
         lim = (4096 - int'(a & 32'hFFF)) / 4;
`endif
         if (lim < b) b = lim;
         exp_ar_q.push_back({a, 8'(b - 1)});
         a = a + 32'(b * 4);
         rem = rem - b;
      end
   endtask

   // drive one command; reports a timeout if cmd_ready never shows
   task automatic issue(input logic [31:0] a, input int len, input bit model, output bit to);
      @(posedge clk); #1;
      cmd_addr  = a;
      cmd_len   = 16'(len);
      cmd_valid = 1'b1;
      if (model) expect_cmd(a, len);
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            to = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit to);
      int start;
      start = done_cnt;
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt > start) begin
            to = 1'b0;
            break;
         end
      end
      @(negedge clk);
   endtask

   // stream ready driver
   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_fix;
      end
   end

   // AXI read slave: accepts ARs, returns one burst at a time with random gaps
   initial begin
      logic [31:0] pend_a[$];
      int          pend_n[$];
      logic [31:0] r_addr, ar_a;
      logic [7:0]  ar_l;
      int          r_rem;
      bit          r_active, ar_hs, r_hs;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = 32'h0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      r_active = 1'b0;
      r_addr   = 32'h0;
      r_rem    = 0;
      forever begin
         @(negedge clk);
         ar_hs = m_axi_arvalid && m_axi_arready;
         r_hs  = m_axi_rvalid && m_axi_rready;
         ar_a  = m_axi_araddr;
         ar_l  = m_axi_arlen;
         @(posedge clk); #1;
         if (!rst_n) begin
            pend_a.delete();
            pend_n.delete();
            r_active = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_arready = 1'b0;
            continue;
         end
         if (ar_hs) begin
            pend_a.push_back(ar_a);
            pend_n.push_back(int'(ar_l) + 1);
         end
         if (r_hs) begin
            r_addr = r_addr + 32'd4;
            r_rem  = r_rem - 1;
            if (r_rem == 0) r_active = 1'b0;
            m_axi_rvalid = 1'b0;
         end
         if (!r_active && pend_a.size() > 0) begin
            r_addr   = pend_a.pop_front();
            r_rem    = pend_n.pop_front();
            r_active = 1'b1;
         end
         if (r_active && !m_axi_rvalid) m_axi_rvalid = ($urandom_range(0, 3) != 0);
         m_axi_rdata   = m_axi_rvalid ? beat_data(r_addr) : 32'h0;
         m_axi_rresp   = (m_axi_rvalid && r_addr == err_addr) ? 2'b10 : 2'b00;
         m_axi_rlast   = m_axi_rvalid && (r_rem == 1);
         m_axi_arready = 1'($urandom_range(0, 1));
      end
   end

   // output monitor: records stream beats, AR handshakes and pulses
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
         if (m_axi_arvalid && m_axi_arready)
            got_ar_q.push_back({m_axi_araddr, m_axi_arlen});
         if (done) done_cnt <= done_cnt + 1;
         if (err) err_cnt <= err_cnt + 1;
         if (err && !done) err_alone_cnt <= err_alone_cnt + 1;
      end
   end

   task automatic test_reset;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr = 32'h0;
      cmd_len = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast}
          !== 8'b1000_0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=10000000",
                  {cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast});
      end
      checks++;
      if ({m_axi_araddr, m_axi_arlen, m_axis_tdata, m_axis_tkeep, dbg_state} !== 78'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0",
                  {m_axi_araddr, m_axi_arlen, m_axis_tdata, m_axis_tkeep, dbg_state});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_burst;
      bit to;
      logic [36:0] g, e;
      logic [39:0] ga, ea;
      int d0, e0;
      tready_rand = 1'b0;
      tready_fix = 1'b1;
      d0 = done_cnt;
      e0 = err_cnt;
      issue(32'h1000, 64, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t1_cmd_accept got=timeout exp=ready"); end
      @(negedge clk);
      checks++;
      if ({m_axi_arvalid, busy, cmd_ready} !== 3'b110) begin
         failures++;
         $display("FAIL t1_ar_latency got=%b exp=110", {m_axi_arvalid, busy, cmd_ready});
      end
      checks++;
      if ({m_axi_araddr, m_axi_arlen} !== {32'h1000, 8'd15}) begin
         failures++;
         $display("FAIL t1_ar_fields got=%h/%0d exp=1000/15", m_axi_araddr, m_axi_arlen);
      end
      wait_done(2000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t1_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL t1_beat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t1_beat got=%h exp=%h", g, e); end
      end
      checks++;
      if (got_ar_q.size() != exp_ar_q.size()) begin
         failures++;
         $display("FAIL t1_ar_count got=%0d exp=%0d", got_ar_q.size(), exp_ar_q.size());
      end
      while (got_ar_q.size() > 0 && exp_ar_q.size() > 0) begin
         ga = got_ar_q.pop_front();
         ea = exp_ar_q.pop_front();
         checks++;
         if (ga !== ea) begin failures++; $display("FAIL t1_ar got=%h exp=%h", ga, ea); end
      end
      checks++;
      if ({done_cnt - d0, err_cnt - e0} !== {32'd1, 32'd0}) begin
         failures++;
         $display("FAIL t1_pulses got=done%0d/err%0d exp=done1/err0", done_cnt - d0, err_cnt - e0);
      end
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

   task automatic test_multi_burst_partial;
      bit to;
      logic [36:0] g, e;
      logic [39:0] ga, ea;
      tready_rand = 1'b1;
      issue(32'h1000, 70, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t2_cmd_accept got=timeout exp=ready"); end
      wait_done(3000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t2_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != 18) begin
         failures++;
         $display("FAIL t2_beat_count got=%0d exp=18", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t2_beat got=%h exp=%h", g, e); end
      end
      checks++;
      if (got_ar_q.size() != 2) begin
         failures++;
         $display("FAIL t2_ar_count got=%0d exp=2", got_ar_q.size());
      end
      while (got_ar_q.size() > 0 && exp_ar_q.size() > 0) begin
         ga = got_ar_q.pop_front();
         ea = exp_ar_q.pop_front();
         checks++;
         if (ga !== ea) begin failures++; $display("FAIL t2_ar got=%h exp=%h", ga, ea); end
      end
      tready_rand = 1'b0;
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

`ifdef MM2S_4K_SPLIT_EN
   task automatic test_4k_split;
      bit to;
      logic [36:0] g, e;
      logic [39:0] ga, ea;
      issue(32'h1FF8, 32, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t3_cmd_accept got=timeout exp=ready"); end
      wait_done(2000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t3_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != 8) begin
         failures++;
         $display("FAIL t3_beat_count got=%0d exp=8", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t3_beat got=%h exp=%h", g, e); end
      end
      checks++;
      if (got_ar_q.size() != 2) begin
         failures++;
         $display("FAIL t3_ar_count got=%0d exp=2", got_ar_q.size());
      end
      while (got_ar_q.size() > 0 && exp_ar_q.size() > 0) begin
         ga = got_ar_q.pop_front();
         ea = exp_ar_q.pop_front();
         checks++;
         if (ga !== ea) begin failures++; $display("FAIL t3_ar got=%h exp=%h", ga, ea); end
      end
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask
`endif

   task automatic test_fifo_backpressure;
      bit to;
      logic [36:0] g, e;
      logic [39:0] ga, ea;
      tready_rand = 1'b0;
      tready_fix = 1'b0;
      issue(32'h4000, 256, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t4_cmd_accept got=timeout exp=ready"); end
      repeat (300) @(negedge clk);
      checks++;
      if (got_ar_q.size() != 2 || got_q.size() != 0) begin
         failures++;
         $display("FAIL t4_stall_ars got=%0d ars/%0d beats exp=2/0", got_ar_q.size(), got_q.size());
      end
      checks++;
      if ({m_axi_arvalid, m_axis_tvalid, dbg_state} !== 4'b0101) begin
         failures++;
         $display("FAIL t4_stall_state got=%b exp=0101", {m_axi_arvalid, m_axis_tvalid, dbg_state});
      end
      tready_fix = 1'b1;
      wait_done(3000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t4_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != 64) begin
         failures++;
         $display("FAIL t4_beat_count got=%0d exp=64", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t4_beat got=%h exp=%h", g, e); end
      end
      checks++;
      if (got_ar_q.size() != 4) begin
         failures++;
         $display("FAIL t4_ar_count got=%0d exp=4", got_ar_q.size());
      end
      while (got_ar_q.size() > 0 && exp_ar_q.size() > 0) begin
         ga = got_ar_q.pop_front();
         ea = exp_ar_q.pop_front();
         checks++;
         if (ga !== ea) begin failures++; $display("FAIL t4_ar got=%h exp=%h", ga, ea); end
      end
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

   task automatic test_rresp_error;
      bit to;
      logic [36:0] g, e;
      int d0, e0, a0;
      tready_fix = 1'b1;
      d0 = done_cnt;
      e0 = err_cnt;
      a0 = err_alone_cnt;
      err_addr = 32'h2008;
      issue(32'h2000, 32, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t5_cmd_accept got=timeout exp=ready"); end
      wait_done(2000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t5_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != 8) begin
         failures++;
         $display("FAIL t5_beat_count got=%0d exp=8", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t5_beat got=%h exp=%h", g, e); end
      end
      checks++;
      if ({done_cnt - d0, err_cnt - e0, err_alone_cnt - a0} !== {32'd1, 32'd1, 32'd0}) begin
         failures++;
         $display("FAIL t5_err_pulse got=done%0d/err%0d/lone%0d exp=1/1/0",
                  done_cnt - d0, err_cnt - e0, err_alone_cnt - a0);
      end
      err_addr = 32'hFFFF_FFFF;
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

   task automatic test_back_to_back;
      bit to;
      logic [36:0] g, e;
      logic [39:0] ga, ea;
      int d0, e0, len;
      logic [31:0] a;
      tready_rand = 1'b1;
      d0 = done_cnt;
      e0 = err_cnt;
      for (int n = 0; n < 6; n++) begin
         len = (n < 4) ? (n + 1) : $urandom_range(5, 200);
         a = 32'h8000 + 32'(n * 32'h1000) + 32'($urandom_range(0, 400) * 4);
         issue(a, len, 1'b1, to);
         checks++;
         if (to) begin failures++; $display("FAIL t6_cmd_accept got=timeout exp=ready"); end
         wait_done(3000, to);
         checks++;
         if (to) begin failures++; $display("FAIL t6_done got=timeout exp=pulse len=%0d", len); end
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL t6_beat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t6_beat got=%h exp=%h", g, e); end
      end
      while (got_ar_q.size() > 0 && exp_ar_q.size() > 0) begin
         ga = got_ar_q.pop_front();
         ea = exp_ar_q.pop_front();
         checks++;
         if (ga !== ea) begin failures++; $display("FAIL t6_ar got=%h exp=%h", ga, ea); end
      end
      checks++;
      if ({done_cnt - d0, err_cnt - e0} !== {32'd6, 32'd0}) begin
         failures++;
         $display("FAIL t6_pulses got=done%0d/err%0d exp=6/0", done_cnt - d0, err_cnt - e0);
      end
      tready_rand = 1'b0;
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

   task automatic test_reset_mid_data;
      bit to;
      logic [36:0] g, e;
      int d0;
      tready_fix = 1'b1;
      issue(32'h5000, 64, 1'b0, to);
      checks++;
      if (to) begin failures++; $display("FAIL t7_cmd_accept got=timeout exp=ready"); end
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (dbg_state == 2'd2) begin
            to = 1'b0;
            break;
         end
      end
      checks++;
      if (to) begin failures++; $display("FAIL t7_reach_data got=timeout exp=state2"); end
      @(posedge clk); #3;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast,
           dbg_state} !== 10'b1000_0000_00) begin
         failures++;
         $display("FAIL t7_async_reset got=%b exp=1000000000",
                  {cmd_ready, busy, done, err, m_axi_arvalid, m_axi_rready, m_axis_tvalid,
                   m_axis_tlast, dbg_state});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin
         failures++;
         $display("FAIL t7_no_done got=%0d exp=0", done_cnt - d0);
      end
      issue(32'h6000, 4, 1'b1, to);
      checks++;
      if (to) begin failures++; $display("FAIL t7_cmd2_accept got=timeout exp=ready"); end
      wait_done(1000, to);
      checks++;
      if (to) begin failures++; $display("FAIL t7_done got=timeout exp=pulse"); end
      checks++;
      if (got_q.size() != 1) begin
         failures++;
         $display("FAIL t7_beat_count got=%0d exp=1", got_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (g !== e) begin failures++; $display("FAIL t7_beat got=%h exp=%h", g, e); end
      end
      got_q.delete(); exp_q.delete(); got_ar_q.delete(); exp_ar_q.delete();
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst_partial();
`ifdef MM2S_4K_SPLIT_EN
      test_4k_split();
`endif
      test_fifo_backpressure();
      test_rresp_error();
      test_back_to_back();
      test_reset_mid_data();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mm2s_engine.md
Name: mm2s_engine

Overview:
Memory-to-stream read engine for the NetTap-DMA core, mirroring the S2MM write path in the other direction. It accepts a (start address, byte length) command and issues AXI-MM read bursts. Returned read data is buffered in an internal FIFO and replayed as an AXI-Stream with correct tkeep and tlast.

Parameters:
MAX_BURST, 16, maximum beats per AR burst (1..256).
FIFO_DEPTH, 32, read-data FIFO entries (power of 2, >= MAX_BURST).
LEN_W, 16, width of cmd_len in bytes.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
cmd_addr  in  32  start byte address, 4-byte aligned
cmd_len  in  LEN_W  transfer length in bytes, nonzero
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
busy  out  1  command in progress
done  out  1  one-cycle pulse after the last stream beat handshakes
err  out  1  one-cycle pulse, coincident with done, if any RRESP != OKAY
m_axi_araddr  out  32  burst address
m_axi_arlen  out  8  beats-1
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  32  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  32  stream data
m_axis_tkeep  out  4  byte enables
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of command

Behaviour:
- Reset (asynchronous assert, synchronous release) clears FSM, FIFO pointers, and counters. All outputs are 0 except cmd_ready=1. Reset mid-transfer abandons the transfer with no done pulse.
- FSM states: IDLE -> ADDR -> DATA -> (ADDR | FLUSH) -> IDLE.
- IDLE: cmd_ready=1. Handshake latches addr, len, and beats_left=ceil(len/4); err_sticky is cleared; goes to ADDR. busy=1 from the next cycle until the cycle done pulses.
- ADDR:
  - burst = min(beats_left, MAX_BURST, 4K-limit).
  - arvalid asserts only when FIFO free entries >= burst; this guarantees R is never stalled by the FIFO.
  - araddr/arlen are held stable while arvalid=1.
  - On AR handshake: go to DATA, addr += burst*4, beats_left -= burst.
- DATA:
  - rready = 1 (space reserved). Each R handshake pushes rdata into the FIFO; rresp != 0 sets err_sticky.
  - On the rlast handshake: if beats_left==0 go to FLUSH, else go to ADDR.
  - Exactly one burst is outstanding at any time.
- FLUSH: wait until the FIFO drains and the final stream beat handshakes; pulse done (and err if err_sticky); return to IDLE. cmd_ready is 0 in every state except IDLE.
- Stream side:
  - m_axis_tvalid = FIFO non-empty. Data/keep/last stay stable until tready.
  - An output beat counter identifies the final beat of the command; that beat carries tlast=1.
  - tkeep=4'hF on all beats except the final one, which uses len[1:0]: 0->F, 1->1, 2->3, 3->7.
- The FIFO supports simultaneous push and pop in the same cycle; the occupancy count is unchanged in that case.
- Minimum latency: cmd handshake -> arvalid is 1 cycle; R handshake -> tvalid is 1 cycle.
- cmd_len=0 or a misaligned address is a protocol violation. Behaviour is undefined and is not checked.

Optional Feature:
MM2S_4K_SPLIT_EN: when defined, the 4K-limit term is (4096 - addr[11:0])/4, so no burst crosses a 4 KB boundary. When undefined, the 4K-limit term is omitted and the caller guarantees the region does not cross a 4 KB boundary.

Test Plan:
1. addr=0x1000, len=64, tready=1 -> one AR (araddr=0x1000, arlen=15); 16 stream beats, tkeep=F, tlast on beat 16; done 1 pulse; err=0.
2. len=70 -> ARs arlen=15 @0x1000, then arlen=1 @0x1040; 18 beats; final tkeep=4'h3 with tlast.
3. With MM2S_4K_SPLIT_EN: addr=0x1FF8, len=32 -> AR @0x1FF8 arlen=1, AR @0x2000 arlen=5; 8 beats total.
4. tready held 0 with FIFO_DEPTH=32, len=256 -> arvalid stalls after 2 bursts (32 beats buffered); resumes on drain; no data lost or reordered.
5. rresp=2'b10 on beat 3 of 8 -> all 8 beats still streamed; done and err pulse together.
6. rst_n asserted mid-DATA -> all outputs reset asynchronously; new cmd len=4 after release -> single beat, tkeep=F, tlast=1, done.
